// File: rtl/onchip_ram_bist_pkg.sv
// Shared types and helpers for the on-chip RAM BIST master.
// Holds the FSM states, the mode encodings, the fill pattern and the error-counter limit.
package onchip_ram_bist_pkg;

  localparam int unsigned PAT_MAX_DATA_W = 512;
  localparam int unsigned PAT_MAX_ADDR_W = 32;
  localparam int unsigned ERRCNT_MAX_W   = 64;

  // Truncated to the counter width at the point of use; all ones at any width.
  localparam logic [ERRCNT_MAX_W-1:0] ERRCNT_SAT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'b00,
    MODE_CHECK      = 2'b01,
    MODE_FILL_CHECK = 2'b10
  } mode_e;

  // Deterministic fill pattern: seed plus the zero-extended word address.
  function automatic logic [PAT_MAX_DATA_W-1:0] pattern(
    input logic [PAT_MAX_DATA_W-1:0] seed,
    input logic [PAT_MAX_ADDR_W-1:0] addr
  );
    return seed + PAT_MAX_DATA_W'(addr);
  endfunction

endpackage

// File: rtl/onchip_ram_bist_master_if.sv
// Avalon-MM host-side bundle between the BIST master and the on-chip RAM slave.
interface onchip_ram_bist_master_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 64
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address,
    output byteenable,
    output chipselect,
    output write,
    output writedata,
    output clken,
    input  readdata
  );

  modport slave (
    input  address,
    input  byteenable,
    input  chipselect,
    input  write,
    input  writedata,
    input  clken,
    output readdata
  );

endinterface

// File: rtl/onchip_ram_bist_checker.sv
// Read-back checker: pipelines the expected word alongside each read issue and
// compares it with the slave's data one cycle later, counting and capturing mismatches.
module onchip_ram_bist_checker
  import onchip_ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [DATA_W-1:0]   expected,
  input  logic [DATA_W-1:0]   readdata,
  output logic                fail,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;
  logic              mismatch;

  assign mismatch = valid_q && (readdata != exp_q);

  // Expected-value pipeline aligned with the slave's 1-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      exp_q   <= '0;
    end else begin
      valid_q <= issue && !clr;
      addr_q  <= issue_addr;
      exp_q   <= expected;
    end
  end

  // Sticky result registers; a new run clears them before its first compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (clr) begin
      fail           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (err_count != ERRCNT_W'(ERRCNT_SAT)) begin
        err_count <= err_count + ERRCNT_W'(1);
      end
      if (!fail) begin
        first_err_addr <= addr_q;
        first_err_data <= readdata;
      end
    end
  end

endmodule

// File: rtl/onchip_ram_bist_master.sv
// Avalon-MM BIST host: fills a word range with seed+address and/or reads it back
// and checks it, one access per cycle, against a 1-cycle-latency on-chip RAM.
module onchip_ram_bist_master
  import onchip_ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  onchip_ram_bist_master_if.master m
);

  state_e            state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              clr;

  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              in_busy;
  logic              read_issue;

  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    return DATA_W'(pattern(PAT_MAX_DATA_W'(s), PAT_MAX_ADDR_W'(a)));
  endfunction

  assign in_busy    = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
  assign read_issue = (state == ST_READ) && !abort;

  // State, range and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      mode_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      seed_q  <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      last_q  <= last_d;
      seed_q  <= seed_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, address walk, and next-cycle bus values derived from the next state.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    mode_d  = mode_q;
    first_d = first_q;
    last_d  = last_q;
    seed_d  = seed_q;
    clr     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          first_d = first_addr;
          last_d  = last_addr;
          seed_d  = seed;
          ptr_d   = first_addr;
          clr     = 1'b1;
          state_d = (mode == 2'(MODE_CHECK)) ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (ptr == last_q) begin
          if (mode_q == 2'(MODE_FILL)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            ptr_d   = first_q;
          end
        end else begin
          ptr_d = ptr + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (ptr == last_q) begin
          state_d = ST_DRAIN;
        end else begin
          ptr_d = ptr + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort && in_busy) begin
      state_d = ST_IDLE;
    end

    cs_d    = (state_d == ST_WRITE) || (state_d == ST_READ);
    wr_d    = (state_d == ST_WRITE);
    busy_d  = cs_d || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    addr_d  = cs_d ? ptr_d : addr_q;
    wdata_d = wr_d ? pat(seed_d, ptr_d) : wdata_q;
  end

  onchip_ram_bist_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ERRCNT_W (ERRCNT_W)
  ) u_checker (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr            (clr),
    .issue          (read_issue),
    .issue_addr     (ptr),
    .expected       (pat(seed_q, ptr)),
    .readdata       (m.readdata),
    .fail           (fail),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign m.address    = addr_q;
  assign m.chipselect = cs_q;
  assign m.write      = wr_q;
  assign m.writedata  = wdata_q;
  assign m.byteenable = '1;
  assign m.clken      = 1'b1;

endmodule

// File: tb/tb_onchip_ram_bist_master.sv
// Self-checking bench: vector table plus scoreboard of expected bus accesses,
// against a 1-cycle-latency RAM model with an optional stuck-at-1 bit 0.
module tb_onchip_ram_bist_master;

  typedef struct {
    logic [1:0]  mode;
    logic [12:0] first;
    logic [12:0] last;
    logic [63:0] seed;
    bit          preload;
    bit          stuck_en;
    logic [12:0] stuck_addr;
    int          done_cyc;
    logic        exp_fail;
    logic [15:0] exp_err;
    logic [12:0] exp_faddr;
    logic [63:0] exp_fdata;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [12:0] addr;
    logic [63:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [12:0] first_addr = '0;
  logic [12:0] last_addr = '0;
  logic [63:0] seed = '0;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] err_count;
  logic [12:0] first_err_addr;
  logic [63:0] first_err_data;

  onchip_ram_bist_master_if #(.ADDR_W(13), .DATA_W(64)) bus ();

  onchip_ram_bist_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .first_addr     (first_addr),
    .last_addr      (last_addr),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .m              (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  bit mon_en = 1'b1;
  acc_t exp_q[$];
  acc_t mon_e;
  vec_t vecs[7];

  always @(posedge clk) cyc++;

  // RAM model: 1-cycle read latency, optional stuck-at-1 on bit 0 of one word.
  logic [63:0] mem [0:8191];
  logic [63:0] rd;
  bit          stuck_en = 1'b0;
  logic [12:0] stuck_addr = '0;
  bit          pre_en = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [63:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.chipselect && bus.write) mem[bus.address] <= bus.writedata;
    rd = mem[bus.address];
    if (stuck_en && bus.address == stuck_addr) rd[0] = 1'b1;
    bus.readdata <= rd;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Scoreboard: every bus access must match the next expected one, in order and cycle.
  always @(negedge clk) begin
    if (mon_en && reset_n && bus.chipselect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: got addr %0h wr %0b at cycle %0d expected none",
                 bus.address, bus.write, cyc - t0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("access", 128'({cyc - t0, bus.write, bus.address,
                            (bus.write ? bus.writedata : 64'd0), busy}),
                      128'({mon_e.cyc, mon_e.wr, mon_e.addr, mon_e.data, 1'b1}));
      end
    end
  end

  task automatic preload(input logic [12:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int inj);
    int n;
    int t;
    bit seen;
    logic [12:0] a;
    n = int'(13'(v.last - v.first)) + 1;
    if (v.preload) begin
      for (int i = 0; i < n; i++) begin
        a = v.first + 13'(i);
        preload(a, v.seed + 64'(a));
      end
    end
    stuck_en = v.stuck_en;
    stuck_addr = v.stuck_addr;
    exp_q.delete();
    t = 1;
    if (v.mode != 2'b01) begin
      for (int i = 0; i < n; i++) begin
        a = v.first + 13'(i);
        exp_q.push_back('{t, 1'b1, a, v.seed + 64'(a)});
        t++;
      end
    end
    if (v.mode != 2'b00) begin
      for (int i = 0; i < n; i++) begin
        a = v.first + 13'(i);
        exp_q.push_back('{t, 1'b0, a, 64'd0});
        t++;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; mode = v.mode; first_addr = v.first; last_addr = v.last; seed = v.seed;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < 64 && !seen; k++) begin
      if (k == inj) begin
        start = 1'b1; mode = 2'b01; first_addr = 13'h40; last_addr = 13'h50; seed = 64'hdead;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 128'(cyc - t0), 128'(v.done_cyc));
        chk("busy_at_done", 128'(busy), 128'(0));
        chk("fail", 128'(fail), 128'(v.exp_fail));
        chk("err_count", 128'(err_count), 128'(v.exp_err));
        chk("first_err_addr", 128'(first_err_addr), 128'(v.exp_faddr));
        chk("first_err_data", 128'(first_err_data), 128'(v.exp_fdata));
        chk("pending_accesses", 128'(exp_q.size()), 128'(0));
      end
      @(posedge clk); #1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done at cycle %0d", v.done_cyc);
    end
    @(negedge clk);
    chk("done_pulse_width", 128'(done), 128'(0));
    stuck_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int dn;
    //            mode   first    last     seed                    pre   stk   stk_addr done fail err    faddr    fdata
    vecs[0] = '{2'b00, 13'h0000, 13'h0003, 64'h1000,                1'b0, 1'b0, 13'h0, 5,  1'b0, 16'd0, 13'h000, 64'h0};
    vecs[1] = '{2'b10, 13'h0000, 13'h0003, 64'h1000,                1'b0, 1'b0, 13'h0, 10, 1'b0, 16'd0, 13'h000, 64'h0};
    vecs[2] = '{2'b10, 13'h0000, 13'h0003, 64'h1000,                1'b0, 1'b1, 13'h2, 10, 1'b1, 16'd1, 13'h002, 64'h1003};
    vecs[3] = '{2'b01, 13'h0000, 13'h0003, 64'h2000,                1'b0, 1'b0, 13'h0, 6,  1'b1, 16'd4, 13'h000, 64'h1000};
    vecs[4] = '{2'b00, 13'h1FFE, 13'h0001, 64'h1000,                1'b0, 1'b0, 13'h0, 5,  1'b0, 16'd0, 13'h000, 64'h0};
    vecs[5] = '{2'b01, 13'h0100, 13'h0100, 64'hABCD_0000_0000_0000, 1'b1, 1'b0, 13'h0, 3,  1'b0, 16'd0, 13'h000, 64'h0};
    vecs[6] = '{2'b11, 13'h1FFF, 13'h0002, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 13'h0, 10, 1'b0, 16'd0, 13'h000, 64'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", 128'({busy, done, fail, err_count, first_err_addr}), 128'(0));
    chk("reset_err_data", 128'(first_err_data), 128'(0));
    chk("reset_bus", 128'({bus.chipselect, bus.write, bus.address, bus.byteenable, bus.clken}),
                     128'({1'b0, 1'b0, 13'd0, 8'hFF, 1'b1}));
    chk("reset_wdata", 128'(bus.writedata), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], -1);

    // start while busy must not disturb the running fill
    run_vec(vecs[0], 2);

    // abort in READ: three compares done, the read in the abort cycle is dropped
    for (int i = 0; i < 4; i++) preload(13'h300 + 13'(i), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('{i + 1, 1'b0, 13'h300 + 13'(i), 64'd0});
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; first_addr = 13'h300; last_addr = 13'h30F; seed = 64'd5;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 128'({bus.chipselect, busy, done}), 128'(0));
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 128'(dn), 128'(0));
    chk("abort_fail", 128'(fail), 128'(1));
    chk("abort_err_count", 128'(err_count), 128'(3));
    chk("abort_first_err", 128'({first_err_addr, first_err_data}), 128'({13'h300, 64'd0}));
    chk("abort_pending", 128'(exp_q.size()), 128'(0));

    // a fresh start clears the retained error state
    run_vec(vecs[0], -1);

    // asynchronous reset in cycle 2 of a fill
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b00; first_addr = 13'h0; last_addr = 13'hF; seed = 64'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("cs_before_reset", 128'(bus.chipselect), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("cs_async_reset", 128'({bus.chipselect, bus.write, busy}), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("reset_no_done", 128'(dn), 128'(0));
    chk("busy_after_reset", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
